// File: rtl/overlay_compositor.sv
// Overlay compositor: keys the overlay colour over the background, applies a
// frame-synchronous vertical wipe and drives registered VGA colour and syncs.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | overlay concealed, wipe_line parked at WIPE_TOP
//   REVEAL  | wipe_line moving down one step per frame
//   SHOWN   | overlay fully revealed, wipe_line at WIPE_BOTTOM
//   CONCEAL | wipe_line moving up one step per frame
`timescale 1ns/1ps
module overlay_compositor #(
  parameter logic [5:0] KEY_COLOR   = 6'b100001,
  parameter int         WIPE_TOP    = 144,
  parameter int         WIPE_BOTTOM = 320,
  parameter int         WIPE_STEP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [5:0] overlay_rgb,
  input  logic [5:0] bg_rgb,
  input  logic       overlay_en,
  output logic [5:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       wipe_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_REVEAL, ST_SHOWN, ST_CONCEAL} state_t;

  localparam logic [9:0] LP_TOP    = 10'(WIPE_TOP);
  localparam logic [9:0] LP_BOTTOM = 10'(WIPE_BOTTOM);
  localparam logic [9:0] LP_STEP   = 10'(WIPE_STEP);

  logic [5:0] r_s1_ovl, r_s1_bg;
  logic [9:0] r_s1_y;
  logic       r_s1_act, r_s1_hs, r_s1_vs, r_s1_vs_d;
  state_t     r_state, w_state_nxt;
  logic [9:0] r_wipe_line, w_line_nxt;
  logic       w_busy_nxt;
  logic       w_tick;
  logic       w_in_wipe;
  logic [5:0] w_rgb_nxt;

  // Stage 1: register all pixel-rate inputs; keep previous vsync for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_ovl  <= '0;
      r_s1_bg   <= '0;
      r_s1_y    <= '0;
      r_s1_act  <= 1'b0;
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
      r_s1_vs_d <= 1'b1;
    end else begin
      r_s1_ovl  <= overlay_rgb;
      r_s1_bg   <= bg_rgb;
      r_s1_y    <= y;
      r_s1_act  <= active;
      r_s1_hs   <= hsync_in;
      r_s1_vs   <= vsync_in;
      r_s1_vs_d <= r_s1_vs;
    end
  end

  // Frame tick on vsync falling edge (in blanking, so wipe changes never tear)
  assign w_tick = r_s1_vs_d & ~r_s1_vs;

  // Wipe state and line register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wipe_line <= LP_TOP;
      wipe_busy   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wipe_line <= w_line_nxt;
      wipe_busy   <= w_busy_nxt;
    end
  end

  // Next state and next wipe line; limits are checked before stepping so the line never wraps
  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_wipe_line;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (overlay_en) begin
            w_state_nxt = ST_REVEAL;
            w_line_nxt  = r_wipe_line + LP_STEP;
          end
        end
        ST_REVEAL: begin
          if (!overlay_en) begin
            w_state_nxt = ST_CONCEAL;
            w_line_nxt  = r_wipe_line - LP_STEP;
          end else if (r_wipe_line >= LP_BOTTOM - LP_STEP) begin
            w_state_nxt = ST_SHOWN;
            w_line_nxt  = LP_BOTTOM;
          end else begin
            w_line_nxt  = r_wipe_line + LP_STEP;
          end
        end
        ST_SHOWN: begin
          if (!overlay_en) begin
            w_state_nxt = ST_CONCEAL;
            w_line_nxt  = r_wipe_line - LP_STEP;
          end
        end
        default: begin
          if (overlay_en) begin
            w_state_nxt = ST_REVEAL;
            w_line_nxt  = r_wipe_line + LP_STEP;
          end else if (r_wipe_line <= LP_TOP + LP_STEP) begin
            w_state_nxt = ST_IDLE;
            w_line_nxt  = LP_TOP;
          end else begin
            w_line_nxt  = r_wipe_line - LP_STEP;
          end
        end
      endcase
    end
  end

  // Busy flag follows the next state so it lines up with the state register
  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_REVEAL) || (w_state_nxt == ST_CONCEAL);
  end

  // Composite: overlay only inside the revealed band [WIPE_TOP, wipe_line), so a
  // parked line at WIPE_TOP hides it completely
  always_comb begin
    w_in_wipe = (r_s1_y >= LP_TOP) && (r_s1_y < r_wipe_line);
    w_rgb_nxt = r_s1_bg;
    if (!r_s1_act) begin
      w_rgb_nxt = '0;
    end else if ((r_s1_ovl != KEY_COLOR) && w_in_wipe) begin
      w_rgb_nxt = r_s1_ovl;
    end
  end

  // Stage 2: registered outputs, syncs delayed to stay aligned with colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= w_rgb_nxt;
      hsync <= r_s1_hs;
      vsync <= r_s1_vs;
    end
  end

  // x is carried only for this sanity check on the incoming timing
  a_x_in_range: assert property (@(posedge clk) disable iff (!rst_n) active |-> (x < 10'd640));

endmodule

// File: tb/tb_overlay_compositor.sv
`timescale 1ns/1ps
module tb_overlay_compositor;

  localparam logic [5:0] KEY = 6'b100001;
  localparam logic [5:0] OVL = 6'b110110;
  localparam logic [5:0] BG  = 6'b000011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x, y;
  logic       active, hsync_in, vsync_in, overlay_en;
  logic [5:0] overlay_rgb, bg_rgb;
  logic [5:0] rgb;
  logic       hsync, vsync, wipe_busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [9:0] exp_wl = 10'd144;

  overlay_compositor dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .overlay_rgb(overlay_rgb),
    .bg_rgb(bg_rgb), .overlay_en(overlay_en), .rgb(rgb), .hsync(hsync),
    .vsync(vsync), .wipe_busy(wipe_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] model_rgb(input logic act, input logic [9:0] yy,
                                           input logic [5:0] o, input logic [9:0] wl);
    if (!act) return 6'd0;
    if (o != KEY && yy >= 10'd144 && yy < wl) return o;
    return BG;
  endfunction

  // Drive one pixel slot and queue what must appear two clocks later
  task automatic cyc(input logic act, input logic hs, input logic vs,
                     input logic [9:0] yy, input logic [9:0] xx, input logic [5:0] o);
    @(posedge clk);
    #1;
    active = act; hsync_in = hs; vsync_in = vs; y = yy; x = xx;
    overlay_rgb = o; bg_rgb = BG;
    exp_q.push_back({model_rgb(act, yy, o, exp_wl), hs, vs});
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // One compact frame: vsync pulse (tick), hsync pulse, then probe pixels
  task automatic frame(input logic en, input logic [9:0] wl, input logic busy);
    overlay_en = en;
    cyc(0, 1, 1, 10'd0, 10'd0, OVL);
    cyc(0, 1, 0, 10'd0, 10'd0, OVL);
    cyc(0, 1, 0, 10'd0, 10'd0, OVL);
    exp_wl = wl;
    cyc(0, 1, 1, 10'd0, 10'd0, OVL);
    cyc(0, 0, 1, 10'd0, 10'd0, OVL);
    cyc(0, 1, 1, 10'd0, 10'd0, OVL);
    if (wl > 10'd144) cyc(1, 1, 1, wl - 10'd1, 10'd10, OVL);
    cyc(1, 1, 1, wl, 10'd11, OVL);
    cyc(1, 1, 1, 10'd150, 10'd12, KEY);
    cyc(1, 1, 1, 10'd151, 10'd13, OVL);
    cyc(1, 1, 1, 10'd200, 10'd14, OVL);
    cyc(1, 1, 1, 10'd319, 10'd15, OVL);
    cyc(0, 1, 1, 10'd0, 10'd0, OVL);
    cyc(0, 1, 1, 10'd0, 10'd0, OVL);
    check("wipe_busy", {31'd0, wipe_busy}, {31'd0, busy});
  endtask

  // Monitor: outputs are presented every clock once the pipeline holds two older slots
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 2) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({rgb, hsync, vsync} !== e) begin
        n_bad++;
        $display("FAIL pipe: got rgb=%b hs=%b vs=%b expected rgb=%b hs=%b vs=%b",
                 rgb, hsync, vsync, e[8:3], e[1], e[0]);
      end
    end
  end

  initial begin
    active = 0; hsync_in = 1; vsync_in = 1; y = '0; x = '0;
    overlay_rgb = OVL; bg_rgb = BG; overlay_en = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rgb", {26'd0, rgb}, 32'd0);
    check("reset hsync", {31'd0, hsync}, 32'd1);
    check("reset vsync", {31'd0, vsync}, 32'd1);
    check("reset busy", {31'd0, wipe_busy}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1;

    frame(0, 10'd144, 0);
    frame(0, 10'd144, 0);

    for (int n = 1; n <= 44; n++) frame(1, 10'(144 + 4 * n), n < 44);
    frame(1, 10'd320, 0);

    for (int n = 1; n <= 44; n++) frame(0, 10'(320 - 4 * n), n < 44);
    frame(0, 10'd144, 0);

    for (int n = 1; n <= 14; n++) frame(1, 10'(144 + 4 * n), 1);
    frame(0, 10'd196, 1);
    overlay_en = 1;
    repeat (100) cyc(0, 1, 1, 10'd0, 10'd0, OVL);
    frame(0, 10'd192, 1);
    frame(1, 10'd196, 1);
    frame(1, 10'd200, 1);

    repeat (4) cyc(1, 0, 1, 10'd190, 10'd20, OVL);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async rst rgb", {26'd0, rgb}, 32'd0);
    check("async rst hsync", {31'd0, hsync}, 32'd1);
    check("async rst vsync", {31'd0, vsync}, 32'd1);
    check("async rst busy", {31'd0, wipe_busy}, 32'd0);
    exp_q.delete();
    exp_wl = 10'd144;
    active = 0; hsync_in = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    frame(1, 10'd148, 1);
    frame(0, 10'd144, 1);
    frame(0, 10'd144, 0);

    repeat (3) cyc(0, 1, 1, 10'd0, 10'd0, OVL);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
